// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_ctrl
// Brief   : Instruction fetch controller with a one-deep output register,
//           decode back-pressure, redirect handling and halt-word detection.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter logic [5:0]  RESET_PC  = 6'd0,
    parameter logic [31:0] HALT_INST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [5:0]  redirect_addr_i,
    output logic [5:0]  rdaddr_o,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_o,
    output logic [5:0]  pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic        halted_o,
    output logic [15:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_fpc;
    logic [5:0]  w_fpc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [5:0]  r_pc;
    logic [5:0]  w_pc_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;

    logic        w_accept;
    logic        w_can_load;
    logic        w_halt_word;

    assign w_accept    = r_valid && inst_ready_i;
    assign w_can_load  = !r_valid || inst_ready_i;
    assign w_halt_word = (inst_i == HALT_INST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirect outranks start, which outranks halt detection and normal loads.
    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_inst_nxt  = r_inst;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;

        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                    w_fpc_nxt   = RESET_PC;
                end
            end

            ST_RUN: begin
                if (redirect_i) begin
                    w_fpc_nxt   = redirect_addr_i;
                    w_valid_nxt = 1'b0;
                end else if (w_can_load) begin
                    w_inst_nxt  = inst_i;
                    w_pc_nxt    = r_fpc;
                    w_valid_nxt = 1'b1;
                    if (w_halt_word) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_fpc_nxt = r_fpc + 6'd1;
                    end
                end
            end

            ST_HALT: begin
                if (redirect_i) begin
                    w_state_nxt = ST_RUN;
                    w_fpc_nxt   = redirect_addr_i;
                    w_valid_nxt = 1'b0;
                end else if (start_i) begin
                    w_state_nxt = ST_RUN;
                    w_fpc_nxt   = RESET_PC;
                    w_valid_nxt = 1'b0;
                end else if (w_accept) begin
                    // The halt word drains once decode takes it; nothing follows.
                    w_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_fpc_nxt   = RESET_PC;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Delivery count is independent of any flush happening on the same edge.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept && (r_cnt != c_CNT_MAX)) begin
            w_cnt_nxt = r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fpc   <= RESET_PC;
            r_inst  <= 32'd0;
            r_pc    <= 6'd0;
            r_valid <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_fpc   <= w_fpc_nxt;
            r_inst  <= w_inst_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign rdaddr_o     = r_fpc;
    assign inst_o       = r_inst;
    assign pc_o         = r_pc;
    assign inst_valid_o = r_valid;
    assign halted_o     = (r_state == ST_HALT);
    assign fetch_cnt_o  = r_cnt;

endmodule
`default_nettype wire
